result_checker: RTL
===================

RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the compared data width.
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, meaning the maximum idle cycles in RUN without valid before abort.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a check sequence.
REQ-006 The block SHALL have port num_checks, input, 8, the number of comparisons in the sequence, sampled with start.
REQ-007 The block SHALL have port valid, input, 1, indicating actual/expected/mask are presented this cycle.
REQ-008 The block SHALL have port actual, input, WIDTH, the DUT output under check.
REQ-009 The block SHALL have port expected, input, WIDTH, the golden value.
REQ-010 The block SHALL have port mask, input, WIDTH, where a 1 bit means compare and a 0 bit means don't-care.
REQ-011 The block SHALL have port ready, output, 1, high only in RUN.
REQ-012 The block SHALL have port done, output, 1, high only in DONE.
REQ-013 The block SHALL have port dutpassed, output, 1, the single-bit pass flag consumed by the all-tests aggregator.
REQ-014 The block SHALL have port fail_count, output, 8, the saturating mismatch count.
REQ-015 The block SHALL have port first_fail_idx, output, 8, the index of the first mismatching check.
REQ-016 The block SHALL have port timed_out, output, 1, set when the sequence aborted on TIMEOUT.

Function
REQ-017 The FSM SHALL have three states, IDLE, RUN and DONE, with a registered state and outputs.
REQ-018 In IDLE, start=1 with num_checks>0 SHALL clear check_idx, fail_count, first_fail_idx, timed_out and the idle counter, latch num_checks, and enter RUN next cycle.
REQ-019 In IDLE or DONE, start=1 with num_checks=0 SHALL enter DONE next cycle with dutpassed=1 and fail_count=0.
REQ-020 In DONE, start=1 SHALL restart exactly as from IDLE, and done SHALL fall the cycle RUN is entered.
REQ-021 In RUN, start SHALL be ignored.
REQ-022 Outside RUN, valid SHALL be ignored and SHALL NOT change any counter.
REQ-023 In RUN with valid=1, a check SHALL be accepted: mismatch = |((actual ^ expected) & mask).
REQ-024 On mismatch, fail_count SHALL increment, saturating at 255.
REQ-025 On the first mismatch of a sequence, first_fail_idx SHALL be set to check_idx and SHALL hold thereafter.
REQ-026 Each accepted check SHALL increment check_idx.
REQ-027 When the accepted check has check_idx = latched num_checks-1, the FSM SHALL enter DONE next cycle, so done asserts one cycle after the last valid.
REQ-028 mask = 0 SHALL always compare as a match.
REQ-029 In RUN, the idle counter SHALL increment each cycle with valid=0 and clear on valid=1.
REQ-030 When the idle counter reaches TIMEOUT, the FSM SHALL set timed_out=1 and enter DONE next cycle.
REQ-031 In DONE, dutpassed SHALL equal (fail_count==0) && !timed_out and SHALL be stable until the next restart.
REQ-032 dutpassed SHALL be 0 in IDLE and RUN, so a consumer never sees a premature pass.
REQ-033 If a last-check valid and the TIMEOUT threshold coincide, the check SHALL be counted and timed_out SHALL stay 0.

Reset
REQ-034 reset_n=0 SHALL immediately force IDLE, ready=0, done=0, dutpassed=0, fail_count=0, first_fail_idx=0 and timed_out=0, including mid-RUN.
REQ-035 After reset_n rises, the block SHALL await start; no pending sequence SHALL resume.

Verification
REQ-036 start, num_checks=4, then 4 matching valids -> done=1 one cycle after the 4th valid, dutpassed=1, fail_count=0.
REQ-037 num_checks=5 with mismatches on checks 2 and 4 -> fail_count=2, first_fail_idx=2, dutpassed=0.
REQ-038 actual=0xFFFF0000, expected=0x0000_0000, mask=0x0000FFFF -> counted as a match.
REQ-039 TIMEOUT=8, num_checks=3, 1 valid then silence -> timed_out=1 after 8 idle cycles, done=1, dutpassed=0.
REQ-040 reset_n pulsed low after 2 of 4 checks -> all outputs 0 immediately; a fresh start of 2 matching checks -> dutpassed=1.
REQ-041 start with num_checks=0 -> done=1 next cycle, dutpassed=1; then 300 mismatches on num_checks=255 -> fail_count saturates at 255.

Source files
------------

// File: rtl/result_checker.sv
// Masked compare scoreboard: counts mismatches over a started sequence of checks
// and reports a single pass flag, with an idle-cycle watchdog that aborts a stalled run.
module result_checker #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       num_checks,
    input  logic             valid,
    input  logic [WIDTH-1:0] actual,
    input  logic [WIDTH-1:0] expected,
    input  logic [WIDTH-1:0] mask,
    output logic             ready,
    output logic             done,
    output logic             dutpassed,
    output logic [7:0]       fail_count,
    output logic [7:0]       first_fail_idx,
    output logic             timed_out
);

    localparam int unsigned IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      num_q, num_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [7:0]      fail_q, fail_d;
    logic [7:0]      first_q, first_d;
    logic            to_q, to_d;
    logic            mismatch_c;

    assign mismatch_c = |((actual ^ expected) & mask);

    // Next-state and next-counter logic; valid has priority over the watchdog
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        num_d   = num_q;
        idle_d  = idle_q;
        fail_d  = fail_q;
        first_d = first_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    idx_d   = 8'd0;
                    idle_d  = '0;
                    fail_d  = 8'd0;
                    first_d = 8'd0;
                    to_d    = 1'b0;
                    num_d   = num_checks;
                    state_d = (num_checks == 8'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (valid) begin
                    idle_d = '0;
                    idx_d  = idx_q + 8'd1;
                    if (mismatch_c) begin
                        if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
                        if (fail_q == 8'd0)  first_d = idx_q;
                    end
                    if (idx_q == num_q - 8'd1) state_d = DONE;
                end else if (idle_q == IW'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= 8'd0;
            num_q     <= 8'd0;
            idle_q    <= '0;
            fail_q    <= 8'd0;
            first_q   <= 8'd0;
            to_q      <= 1'b0;
            ready     <= 1'b0;
            done      <= 1'b0;
            dutpassed <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            num_q     <= num_d;
            idle_q    <= idle_d;
            fail_q    <= fail_d;
            first_q   <= first_d;
            to_q      <= to_d;
            ready     <= (state_d == RUN);
            done      <= (state_d == DONE);
            dutpassed <= (state_d == DONE) && (fail_d == 8'd0) && !to_d;
        end
    end

    assign fail_count     = fail_q;
    assign first_fail_idx = first_q;
    assign timed_out      = to_q;

endmodule
